// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control sequencer for the RV32I datapath. It steps each instruction through
// FETCH/IR/EXEC/MEM/WB and drives all datapath selects and enables from the state and the held instruction.
module cpu_ctrl_fsm #(
   parameter int CNT_W            = 4,
   parameter bit RESET_STATE_HALT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             BrEq,
   input  logic             BrLT,
   output logic             pc_en,
   output logic             PCSel,
   output logic             ir_en,
   output logic             AddrSel,
   output logic             ramEn,
   output logic             MemRW,
   output logic [2:0]       ImmSel,
   output logic             ASel,
   output logic             BSel,
   output logic             BrUn,
   output logic [3:0]       ALUop,
   output logic             RegWEn,
   output logic [1:0]       WBSel,
   output logic [CNT_W-1:0] cycleCount,
   output logic             instr_done,
   output logic             halt
);

   typedef enum logic [2:0] {
      S_FETCH, S_IR, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_BAD
   } kind_t;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;

   logic [6:0] opcode;
   logic [2:0] funct3;
   kind_t      kind;
   logic       dec_asel, dec_bsel, taken;
   logic [2:0] dec_imm;
   logic [3:0] dec_alu;
   logic       unused_instr_bits;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // Operand selects are decoded once and reused unchanged in EXEC, MEM and WB
   always_comb begin
      kind     = K_BAD;
      dec_asel = 1'b0;
      dec_bsel = 1'b0;
      dec_imm  = IMM_I;
      dec_alu  = 4'b0000;
      case (opcode)
         7'b0110011: begin
            kind    = K_R;
            dec_alu = {instr[30], funct3};
         end
         7'b0010011: begin
            kind     = K_I;
            dec_bsel = 1'b1;
            dec_alu  = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
         end
         7'b0000011: begin
            if (funct3 == 3'b010) begin
               kind     = K_LW;
               dec_bsel = 1'b1;
            end
         end
         7'b0100011: begin
            if (funct3 == 3'b010) begin
               kind     = K_SW;
               dec_bsel = 1'b1;
               dec_imm  = IMM_S;
            end
         end
         7'b1100011: begin
            if (funct3[2:1] != 2'b01) begin
               kind     = K_BR;
               dec_asel = 1'b1;
               dec_bsel = 1'b1;
               dec_imm  = IMM_B;
            end
         end
         7'b1101111: begin
            kind     = K_JAL;
            dec_asel = 1'b1;
            dec_bsel = 1'b1;
            dec_imm  = IMM_J;
         end
         default: kind = K_BAD;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:        taken = BrEq;
         3'b001:        taken = ~BrEq;
         3'b100, 3'b110: taken = BrLT;
         default:       taken = ~BrLT;
      endcase
   end

   // Holding rst high forces every output to zero regardless of the current state
   always_comb begin
      state_next = state_reg;
      pc_en      = 1'b0;
      PCSel      = 1'b0;
      ir_en      = 1'b0;
      AddrSel    = 1'b0;
      ramEn      = 1'b0;
      MemRW      = 1'b0;
      ImmSel     = 3'd0;
      ASel       = 1'b0;
      BSel       = 1'b0;
      BrUn       = 1'b0;
      ALUop      = 4'b0000;
      RegWEn     = 1'b0;
      WBSel      = 2'd0;
      instr_done = 1'b0;
      halt       = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_FETCH: begin
               ramEn      = 1'b1;
               state_next = S_IR;
            end
            S_IR: begin
               ir_en      = 1'b1;
               state_next = S_EXEC;
            end
            S_EXEC: begin
               if (kind == K_BAD) begin
                  state_next = S_HALT;
               end else begin
                  ASel   = dec_asel;
                  BSel   = dec_bsel;
                  ImmSel = dec_imm;
                  ALUop  = dec_alu;
                  case (kind)
                     K_BR: begin
                        BrUn       = funct3[1];
                        pc_en      = 1'b1;
                        PCSel      = taken;
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                     end
                     K_LW, K_SW: state_next = S_MEM;
                     default:    state_next = S_WB;
                  endcase
               end
            end
            S_MEM: begin
               ASel    = dec_asel;
               BSel    = dec_bsel;
               ImmSel  = dec_imm;
               ALUop   = dec_alu;
               ramEn   = 1'b1;
               AddrSel = 1'b1;
               if (kind == K_SW) begin
                  MemRW      = 1'b1;
                  pc_en      = 1'b1;
                  instr_done = 1'b1;
                  state_next = S_FETCH;
               end else begin
                  state_next = S_WB;
               end
            end
            S_WB: begin
               ASel       = dec_asel;
               BSel       = dec_bsel;
               ImmSel     = dec_imm;
               ALUop      = dec_alu;
               RegWEn     = 1'b1;
               WBSel      = (kind == K_LW) ? 2'd1 : (kind == K_JAL) ? 2'd2 : 2'd0;
               pc_en      = 1'b1;
               PCSel      = (kind == K_JAL);
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
            S_HALT: begin
               halt = 1'b1;
            end
            default: state_next = S_FETCH;
         endcase
      end
   end

   // The count restarts on every return to FETCH and is frozen once halted
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RESET_STATE_HALT ? S_HALT : S_FETCH;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next == S_FETCH)
            cnt_reg <= '0;
         else if (state_reg != S_HALT && cnt_reg != '1)
            cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign cycleCount = rst ? '0 : cnt_reg;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: per-cycle expected output vectors are queued when an
// instruction is presented and popped/compared as the sequencer steps through it.
module tb_cpu_ctrl_fsm;

   typedef struct packed {
      logic       pc_en, pcsel, ir_en, addrsel, ramen, memrw;
      logic [2:0] immsel;
      logic       asel, bsel, brun;
      logic [3:0] aluop;
      logic       regwen;
      logic [1:0] wbsel;
      logic [3:0] cc;
      logic       done, halt;
   } ov_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        BrEq = 1'b0, BrLT = 1'b0;
   logic        pc_en, PCSel, ir_en, AddrSel, ramEn, MemRW, ASel, BSel, BrUn, RegWEn;
   logic        instr_done, halt;
   logic [2:0]  ImmSel;
   logic [3:0]  ALUop, cycleCount;
   logic [1:0]  WBSel;

   ov_t obs;
   ov_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   cpu_ctrl_fsm #(.CNT_W(4), .RESET_STATE_HALT(1'b0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .BrEq(BrEq), .BrLT(BrLT),
      .pc_en(pc_en), .PCSel(PCSel), .ir_en(ir_en), .AddrSel(AddrSel), .ramEn(ramEn),
      .MemRW(MemRW), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn), .ALUop(ALUop),
      .RegWEn(RegWEn), .WBSel(WBSel), .cycleCount(cycleCount), .instr_done(instr_done),
      .halt(halt)
   );

   assign obs = {pc_en, PCSel, ir_en, AddrSel, ramEn, MemRW, ImmSel, ASel, BSel, BrUn,
                 ALUop, RegWEn, WBSel, cycleCount, instr_done, halt};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic ov_t f_fetch();
      ov_t e = '0;
      e.ramen = 1'b1;
      return e;
   endfunction

   function automatic ov_t f_ir();
      ov_t e = '0;
      e.ir_en = 1'b1;
      e.cc    = 4'd1;
      return e;
   endfunction

   function automatic ov_t f_ops(input logic a, input logic b, input logic [2:0] imm,
                                 input logic [3:0] alu, input logic [3:0] cc);
      ov_t e = '0;
      e.asel   = a;
      e.bsel   = b;
      e.immsel = imm;
      e.aluop  = alu;
      e.cc     = cc;
      return e;
   endfunction

   task automatic test_reset();
      ov_t e;
      int  cyc = 0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      sb.push_back(ov_t'('0));
      sb.push_back(ov_t'('0));
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL reset cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      rst = 1'b0;
      $display("txn reset held %0d cycles", cyc);
   endtask

   task automatic test_alu(input logic [31:0] ins, input logic bsel, input logic [3:0] alu,
                           input string nm);
      ov_t e;
      int  cyc = 0;
      instr = ins;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = f_ops(1'b0, bsel, 3'd0, alu, 4'd2);
      sb.push_back(e);
      e.regwen = 1'b1; e.pc_en = 1'b1; e.done = 1'b1; e.cc = 4'd3;
      sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL %s cyc%0d: got %h expected %h", nm, cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      $display("txn %s instr=%h cycles=%0d", nm, ins, cyc);
   endtask

   task automatic test_lw();
      ov_t e;
      int  cyc = 0;
      instr = 32'h0040A183;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = f_ops(1'b0, 1'b1, 3'd0, 4'd0, 4'd2);
      sb.push_back(e);
      e.ramen = 1'b1; e.addrsel = 1'b1; e.cc = 4'd3;
      sb.push_back(e);
      e = f_ops(1'b0, 1'b1, 3'd0, 4'd0, 4'd4);
      e.regwen = 1'b1; e.wbsel = 2'd1; e.pc_en = 1'b1; e.done = 1'b1;
      sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL lw cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      $display("txn lw instr=%h cycles=%0d", instr, cyc);
   endtask

   task automatic test_sw();
      ov_t e;
      int  cyc = 0;
      instr = 32'h0030A223;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = f_ops(1'b0, 1'b1, 3'd1, 4'd0, 4'd2);
      sb.push_back(e);
      e.ramen = 1'b1; e.addrsel = 1'b1; e.memrw = 1'b1; e.pc_en = 1'b1; e.done = 1'b1;
      e.cc = 4'd3;
      sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL sw cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      $display("txn sw instr=%h cycles=%0d", instr, cyc);
   endtask

   task automatic test_branch(input logic [31:0] ins, input logic eq, input logic lt,
                              input logic un, input logic tk, input string nm);
      ov_t e;
      int  cyc = 0;
      instr = ins;
      BrEq  = eq;
      BrLT  = lt;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = f_ops(1'b1, 1'b1, 3'd2, 4'd0, 4'd2);
      e.brun = un; e.pc_en = 1'b1; e.pcsel = tk; e.done = 1'b1;
      sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL %s cyc%0d: got %h expected %h", nm, cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      BrEq = 1'b0;
      BrLT = 1'b0;
      $display("txn %s instr=%h cycles=%0d taken=%0b", nm, ins, cyc, tk);
   endtask

   task automatic test_jal();
      ov_t e;
      int  cyc = 0;
      instr = 32'h008000EF;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = f_ops(1'b1, 1'b1, 3'd3, 4'd0, 4'd2);
      sb.push_back(e);
      e.regwen = 1'b1; e.wbsel = 2'd2; e.pc_en = 1'b1; e.pcsel = 1'b1; e.done = 1'b1;
      e.cc = 4'd3;
      sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL jal cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      $display("txn jal instr=%h cycles=%0d", instr, cyc);
   endtask

   task automatic test_illegal();
      ov_t e;
      int  cyc = 0;
      instr = 32'hFFFFFFFF;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = '0; e.cc = 4'd2;
      sb.push_back(e);
      e = '0; e.halt = 1'b1; e.cc = 4'd3;
      for (int i = 0; i < 10; i++) sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL illegal cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      // Only reset leaves HALT
      rst = 1'b1;
      sb.push_back(ov_t'('0));
      sb.push_back(ov_t'('0));
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL halt_rst cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      rst = 1'b0;
      $display("txn illegal instr=%h cycles=%0d", 32'hFFFFFFFF, cyc);
   endtask

   task automatic test_reset_mid_lw();
      ov_t e;
      int  cyc = 0;
      instr = 32'h0040A183;
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      e = f_ops(1'b0, 1'b1, 3'd0, 4'd0, 4'd2);
      sb.push_back(e);
      e.ramen = 1'b1; e.addrsel = 1'b1; e.cc = 4'd3;
      sb.push_back(e);
      sb.push_back(ov_t'('0));
      sb.push_back(f_fetch());
      sb.push_back(f_ir());
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL lw_abort cyc%0d: got %h expected %h", cyc, obs, e);
         end
         // rst rises in the middle of MEM and is released one cycle later
         if (cyc == 3) rst = 1'b1;
         cyc++;
         @(posedge clk); @(negedge clk);
         if (cyc == 5) rst = 1'b0;
      end
      // Finish the restarted LW so the next instruction starts from FETCH
      e = f_ops(1'b0, 1'b1, 3'd0, 4'd0, 4'd2);
      sb.push_back(e);
      e.ramen = 1'b1; e.addrsel = 1'b1; e.cc = 4'd3;
      sb.push_back(e);
      e = f_ops(1'b0, 1'b1, 3'd0, 4'd0, 4'd4);
      e.regwen = 1'b1; e.wbsel = 2'd1; e.pc_en = 1'b1; e.done = 1'b1;
      sb.push_back(e);
      while (sb.size() > 0) begin
         #1;
         e = sb.pop_front();
         n_cmp++;
         if (obs !== e) begin
            n_bad++;
            $display("FAIL lw_restart cyc%0d: got %h expected %h", cyc, obs, e);
         end
         cyc++;
         @(posedge clk); @(negedge clk);
      end
      $display("txn lw_abort instr=%h cycles=%0d", instr, cyc);
   endtask

   initial begin
      test_reset();
      test_alu(32'h002081B3, 1'b0, 4'b0000, "add");
      test_alu(32'h402081B3, 1'b0, 4'b1000, "sub");
      test_alu(32'h4030D093, 1'b1, 4'b1101, "srai");
      test_alu(32'h40008093, 1'b1, 4'b0000, "addi_bit30");
      test_lw();
      test_sw();
      test_branch(32'h0020E463, 1'b0, 1'b1, 1'b1, 1'b1, "bltu_taken");
      test_branch(32'h00208463, 1'b0, 1'b0, 1'b0, 1'b0, "beq_not");
      test_branch(32'h00209463, 1'b0, 1'b0, 1'b0, 1'b1, "bne_taken");
      test_branch(32'h0020D463, 1'b0, 1'b1, 1'b0, 1'b0, "bge_not");
      test_jal();
      test_illegal();
      test_reset_mid_lw();
      test_alu(32'h002081B3, 1'b0, 4'b0000, "add_after");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
